// File: rtl/npu_pkg.sv
// Shared NPU definitions: PE control encodings and data-bus arbiter types/defaults.
package npu_pkg;

  localparam int unsigned NUM_PE_DEF   = 8;
  localparam logic [4:0]  MAX_HOLD_DEF = 5'd24;
  localparam int unsigned PE_ID_W      = 3;

  typedef enum logic [2:0] {
    PE_CTRL_NOP,
    PE_CTRL_LOAD,
    PE_CTRL_MAC,
    PE_CTRL_STORE,
    PE_CTRL_FLUSH
  } pe_ctrl_e;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_HOST,
    ARB_TURN
  } arb_state_e;

endpackage

// File: rtl/pe_bus_arb_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after (last_id+1) mod NUM_PE.
module rr_pick #(
  parameter int unsigned NUM_PE = 8,
  parameter int unsigned ID_W   = 3
) (
  input  logic [NUM_PE-1:0] req,
  input  logic [ID_W-1:0]   last_id,
  output logic [NUM_PE-1:0] winner,
  output logic [ID_W-1:0]   winner_id,
  output logic              any
);

  logic [ID_W-1:0] k;

  always_comb begin
    winner    = '0;
    winner_id = '0;
    any       = 1'b0;
    k         = '0;
    for (int unsigned i = 1; i <= NUM_PE; i++) begin
      k = ID_W'((32'(last_id) + i) % NUM_PE);
      if (!any && req[k]) begin
        any       = 1'b1;
        winner[k] = 1'b1;
        winner_id = k;
      end
    end
  end

endmodule

// File: rtl/pe_bus_arb.sv
// Shared data-bus arbiter: host priority, round-robin among PEs, hold timeout,
// and a one-cycle turnaround between owners.
module pe_bus_arb
  import npu_pkg::*;
#(
  parameter int unsigned NUM_PE   = NUM_PE_DEF,
  parameter logic [4:0]  MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 host_we,
  input  logic [NUM_PE-1:0]    req,
  input  logic [NUM_PE-1:0]    done,
  output logic [NUM_PE-1:0]    gnt,
  output logic                 host_gnt,
  output logic [PE_ID_W-1:0]   gnt_id,
  output logic                 bus_busy,
  output logic                 timeout_err,
  output logic [PE_ID_W-1:0]   err_id
);

  arb_state_e           state, state_nxt;
  logic [NUM_PE-1:0]    gnt_nxt, win_oh;
  logic                 host_gnt_nxt, timeout_err_nxt, win_any;
  logic [PE_ID_W-1:0]   gnt_id_nxt, last_id, last_id_nxt, win_id, err_id_nxt;
  logic [4:0]           hold_cnt, hold_cnt_nxt;
  logic                 release_hit, limit_hit;

  rr_pick #(
    .NUM_PE (NUM_PE),
    .ID_W   (PE_ID_W)
  ) u_pick (
    .req       (req),
    .last_id   (last_id),
    .winner    (win_oh),
    .winner_id (win_id),
    .any       (win_any)
  );

  // Only the holder's done/req bits matter; gnt_id names the holder in GRANT.
  assign release_hit = done[gnt_id] | ~req[gnt_id];
  assign limit_hit   = (hold_cnt == MAX_HOLD - 5'd1);
  assign bus_busy    = (state != ARB_IDLE);

  always_comb begin
    state_nxt       = state;
    gnt_nxt         = gnt;
    host_gnt_nxt    = host_gnt;
    gnt_id_nxt      = gnt_id;
    last_id_nxt     = last_id;
    hold_cnt_nxt    = hold_cnt;
    timeout_err_nxt = timeout_err;
    err_id_nxt      = err_id;
    unique case (state)
      ARB_IDLE: begin
        if (host_we) begin
          state_nxt    = ARB_HOST;
          host_gnt_nxt = 1'b1;
        end else if (win_any) begin
          state_nxt    = ARB_GRANT;
          gnt_nxt      = win_oh;
          gnt_id_nxt   = win_id;
          last_id_nxt  = win_id;
          hold_cnt_nxt = '0;
        end
      end
      ARB_GRANT: begin
        hold_cnt_nxt = hold_cnt + 5'd1;
        if (release_hit || limit_hit) begin
          state_nxt = ARB_TURN;
          gnt_nxt   = '0;
        end
        // A release coinciding with the limit is a normal release.
        if (limit_hit && !release_hit) begin
          timeout_err_nxt = 1'b1;
          if (!timeout_err) err_id_nxt = gnt_id;
        end
      end
      ARB_HOST: begin
        if (!host_we) begin
          state_nxt    = ARB_TURN;
          host_gnt_nxt = 1'b0;
        end
      end
      ARB_TURN: state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ARB_IDLE;
      gnt         <= '0;
      host_gnt    <= 1'b0;
      gnt_id      <= '0;
      last_id     <= PE_ID_W'(NUM_PE - 1);
      hold_cnt    <= '0;
      timeout_err <= 1'b0;
      err_id      <= '0;
    end else begin
      state       <= state_nxt;
      gnt         <= gnt_nxt;
      host_gnt    <= host_gnt_nxt;
      gnt_id      <= gnt_id_nxt;
      last_id     <= last_id_nxt;
      hold_cnt    <= hold_cnt_nxt;
      timeout_err <= timeout_err_nxt;
      err_id      <= err_id_nxt;
    end
  end

endmodule
